// File: rtl/jtkiwi_objdraw.sv
// Sprite line drawer: fetches one 16-pixel sprite row (two 32-bit ROM words) and
// paints it into a double-buffered line buffer that is erased as it is read out.
module jtkiwi_objdraw (
    input  logic        rst,
    input  logic        clk,
    input  logic        pxl_cen,
    input  logic        hs,
    input  logic        flip,
    input  logic        draw,
    input  logic [12:0] code,
    input  logic [8:0]  xpos,
    input  logic [4:0]  pal,
    input  logic        hflip,
    input  logic [3:0]  ysub,
    output logic        busy,
    output logic [17:0] rom_addr,
    output logic        rom_cs,
    input  logic        rom_ok,
    input  logic [31:0] rom_data,
    input  logic [8:0]  hdump,
    output logic [8:0]  pxl
);

    typedef enum logic [1:0] { IDLE, REQ, DRAW } state_t;

    state_t      st;
    logic        hs_l, rd_bank, wr_bank, half, lhflip;
    logic [12:0] lcode;
    logic [8:0]  lxpos;
    logic [4:0]  lpal;
    logic [3:0]  lysub;
    logic [31:0] data;
    logic [2:0]  cnt;

    logic [8:0]  line_mem [0:1023];
    logic        er_en;
    logic [9:0]  er_addr;

    logic [2:0]  nib_sel;
    logic [3:0]  colour;
    logic [8:0]  wr_col, rd_col;
    logic        wr_en;

    // hflip mirrors nibble order inside each word; the half swap is done on the fetch
    assign nib_sel = lhflip ? ~cnt : cnt;
    assign colour  = data[{nib_sel, 2'b00} +: 4];
    assign wr_col  = lxpos + {5'd0, half, cnt};
    assign wr_en   = (st == DRAW) && (colour != 4'd0);
    assign rd_col  = flip ? ~hdump : hdump;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_l    <= 1'b0;
            rd_bank <= 1'b0;
        end else begin
            hs_l <= hs;
            if (hs && !hs_l) rd_bank <= ~rd_bank;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= IDLE;
            busy     <= 1'b0;
            rom_cs   <= 1'b0;
            rom_addr <= 18'd0;
            wr_bank  <= 1'b0;
            half     <= 1'b0;
            lhflip   <= 1'b0;
            lcode    <= 13'd0;
            lxpos    <= 9'd0;
            lpal     <= 5'd0;
            lysub    <= 4'd0;
            data     <= 32'd0;
            cnt      <= 3'd0;
        end else begin
            case (st)
                IDLE: if (draw) begin
                    lcode    <= code;
                    lxpos    <= xpos;
                    lpal     <= pal;
                    lhflip   <= hflip;
                    lysub    <= ysub;
                    wr_bank  <= ~rd_bank;
                    half     <= 1'b0;
                    rom_addr <= {code, hflip, ysub};
                    rom_cs   <= 1'b1;
                    busy     <= 1'b1;
                    st       <= REQ;
                end
                REQ: if (rom_cs && rom_ok) begin
                    data   <= rom_data;
                    rom_cs <= 1'b0;
                    cnt    <= 3'd0;
                    st     <= DRAW;
                end
                DRAW: begin
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        if (!half) begin
                            half     <= 1'b1;
                            rom_addr <= {lcode, ~lhflip, lysub};
                            rom_cs   <= 1'b1;
                            st       <= REQ;
                        end else begin
                            busy <= 1'b0;
                            st   <= IDLE;
                        end
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pxl     <= 9'd0;
            er_en   <= 1'b0;
            er_addr <= 10'd0;
        end else begin
            er_en <= pxl_cen;
            if (pxl_cen) begin
                pxl     <= line_mem[{rd_bank, rd_col}];
                er_addr <= {rd_bank, rd_col};
            end
        end
    end

    // The erase is assigned last so it overrides a sprite write to the same cell
    always_ff @(posedge clk) begin
        if (wr_en) line_mem[{wr_bank, wr_col}] <= {lpal, colour};
        if (er_en) line_mem[er_addr] <= 9'd0;
    end

endmodule

// File: tb/tb_jtkiwi_objdraw.sv
// Self-checking bench for jtkiwi_objdraw: directed table, stall/reset sequences
// and randomized sprites compared against a line-buffer model.
module tb_jtkiwi_objdraw;

    logic        rst, clk, pxl_cen, hs, flip, draw, hflip, busy, rom_cs, rom_ok;
    logic [12:0] code;
    logic [8:0]  xpos, hdump, pxl;
    logic [4:0]  pal;
    logic [3:0]  ysub;
    logic [17:0] rom_addr;
    logic [31:0] rom_data;

    int n_cmp = 0, n_err = 0;
    int ok_mode = 0;
    logic [17:0] fetch_q[$];
    logic [8:0]  mbuf [0:1][0:511];
    logic        mrb;

    jtkiwi_objdraw dut (
        .rst(rst), .clk(clk), .pxl_cen(pxl_cen), .hs(hs), .flip(flip), .draw(draw),
        .code(code), .xpos(xpos), .pal(pal), .hflip(hflip), .ysub(ysub), .busy(busy),
        .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_ok(rom_ok), .rom_data(rom_data),
        .hdump(hdump), .pxl(pxl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [17:0] a);
        if (a == 18'h00025) return 32'h87654321;
        if (a == 18'h00035) return 32'h0FEDCBA9;
        return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction
    assign rom_data = rom_word(rom_addr);

    always @(negedge clk)
        rom_ok = (ok_mode == 0) ? 1'b1 : (ok_mode == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);

    always @(posedge clk) if (rom_cs && rom_ok) fetch_q.push_back(rom_addr);

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Reference: pixel p of the row comes from ROM half (p/8)^hf, nibble mirrored by hf
    task automatic model_draw(input logic [12:0] c, input logic [8:0] x, input logic [4:0] p,
                              input logic hf, input logic [3:0] ys, input logic wb, input int npix);
        for (int i = 0; i < npix; i++) begin
            logic [31:0] w;
            int n;
            logic [3:0] col;
            w   = rom_word({c, logic'((i / 8) % 2) ^ hf, ys});
            n   = hf ? 7 - (i % 8) : i % 8;
            col = w[4*n +: 4];
            if (col != 4'd0) mbuf[wb][(int'(x) + i) % 512] = {p, col};
        end
    endtask

    task automatic do_draw(input logic [12:0] c, input logic [8:0] x, input logic [4:0] p,
                           input logic hf, input logic [3:0] ys, input int stall, output int cyc);
        logic wb;
        code = c; xpos = x; pal = p; hflip = hf; ysub = ys;
        draw = 1'b1; wb = ~mrb;
        tick; draw = 1'b0; cyc = 1;
        for (int i = 0; i < stall; i++) begin
            check("stall_cs", rom_cs, 1);
            check("stall_addr", rom_addr, {c, hf, ys});
            if (i == 1) begin code = 13'h0ABC; draw = 1'b1; end
            else draw = 1'b0;
            tick; cyc++;
        end
        draw = 1'b0;
        if (stall > 0) ok_mode = 0;
        while (busy && cyc < 300) begin tick; cyc++; end
        if (busy) check("busy_timeout", busy, 0);
        model_draw(c, x, p, hf, ys, wb, 16);
    endtask

    task automatic hs_pulse;
        hs = 1'b1; tick; tick; hs = 1'b0; tick;
        mrb = ~mrb;
    endtask

    task automatic read_px(input logic [8:0] h, output logic [8:0] act, output logic [8:0] exp);
        logic [8:0] a;
        hdump = h; pxl_cen = 1'b1;
        tick; pxl_cen = 1'b0;
        act = pxl;
        a = flip ? ~h : h;
        exp = mbuf[mrb][a];
        mbuf[mrb][a] = 9'd0;
    endtask

    // mode 0: flush only, 1: compare with model, 2: compare with all-zero
    task automatic read_line(input int mode);
        logic [8:0] act, exp;
        for (int h = 0; h < 512; h++) begin
            read_px(9'(h), act, exp);
            if (mode == 1) check("line_px", {h[15:0], 7'd0, act}, {h[15:0], 7'd0, exp});
            if (mode == 2) check("erase_px", {h[15:0], 7'd0, act}, {h[15:0], 16'd0});
        end
    endtask

    typedef struct {
        logic [8:0]  xpos;
        logic        hf;
        logic [8:0]  col;
        logic [8:0]  exp;
        logic [17:0] f0;
    } vec_t;
    vec_t tbl [11];

    initial begin
        int cyc;
        logic [8:0] act, exp;
        tbl[0]  = '{9'h010, 1'b0, 9'h010, 9'h031, 18'h00025};
        tbl[1]  = '{9'h010, 1'b0, 9'h017, 9'h038, 18'h00025};
        tbl[2]  = '{9'h010, 1'b0, 9'h018, 9'h039, 18'h00025};
        tbl[3]  = '{9'h010, 1'b0, 9'h01F, 9'h000, 18'h00025};
        tbl[4]  = '{9'h010, 1'b1, 9'h011, 9'h03F, 18'h00035};
        tbl[5]  = '{9'h010, 1'b1, 9'h017, 9'h039, 18'h00035};
        tbl[6]  = '{9'h010, 1'b1, 9'h018, 9'h038, 18'h00035};
        tbl[7]  = '{9'h1FC, 1'b0, 9'h1FC, 9'h031, 18'h00025};
        tbl[8]  = '{9'h1FC, 1'b0, 9'h003, 9'h038, 18'h00025};
        tbl[9]  = '{9'h1FC, 1'b0, 9'h00A, 9'h03F, 18'h00025};
        tbl[10] = '{9'h1FC, 1'b0, 9'h00B, 9'h000, 18'h00025};

        rst = 1'b1; pxl_cen = 0; hs = 0; flip = 0; draw = 0; code = 0; xpos = 0;
        pal = 0; hflip = 0; ysub = 0; hdump = 0; mrb = 1'b0;
        repeat (3) tick;
        check("rst_busy", busy, 0);
        check("rst_rom_cs", rom_cs, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_pxl", pxl, 0);
        rst = 1'b0; tick;

        // RAM is not cleared by reset: flush both banks before modelling
        hs_pulse; read_line(0);
        hs_pulse; read_line(0);
        for (int b = 0; b < 2; b++) for (int i = 0; i < 512; i++) mbuf[b][i] = 9'd0;

        for (int t = 0; t < 11; t++) begin
            fetch_q.delete();
            do_draw(13'h0001, tbl[t].xpos, 5'd3, tbl[t].hf, 4'd5, 0, cyc);
            check("busy_cycles", cyc, 19);
            check("fetch0", fetch_q.size() > 0 ? fetch_q[0] : 18'h3FFFF, tbl[t].f0);
            check("fetch1", fetch_q.size() > 1 ? fetch_q[1] : 18'h3FFFF, tbl[t].f0 ^ 18'h10);
            hs_pulse;
            read_px(tbl[t].col, act, exp);
            check("tbl_px", act, tbl[t].exp);
            read_line(1);
        end

        // flip read-out
        do_draw(13'h0001, 9'h010, 5'd3, 1'b0, 4'd5, 0, cyc);
        hs_pulse; flip = 1'b1;
        read_px(9'h1EF, act, exp);
        check("flip_px", act, 9'h031);
        read_line(1); flip = 1'b0;

        // SDRAM stall with an ignored second draw
        fetch_q.delete(); ok_mode = 1;
        do_draw(13'h0001, 9'h080, 5'd7, 1'b0, 4'd5, 5, cyc);
        check("stall_busy_cycles", cyc, 24);
        check("stall_fetch_n", fetch_q.size(), 2);
        check("stall_fetch1", fetch_q.size() > 1 ? fetch_q[1] : 18'h3FFFF, 18'h00035);
        hs_pulse; read_line(1);

        // erase: same bank after two more hs edges is empty
        hs_pulse; hs_pulse; read_line(2);

        // randomized sprites, overlapping, with random SDRAM latency and read flip
        for (int ln = 0; ln < 3; ln++) begin
            ok_mode = 2;
            for (int s = 0; s < 5; s++) begin
                logic [12:0] c; logic [8:0] x; logic [4:0] p; logic hf; logic [3:0] ys;
                c = 13'($urandom); x = 9'($urandom); p = 5'($urandom);
                hf = 1'($urandom); ys = 4'($urandom);
                fetch_q.delete();
                do_draw(c, x, p, hf, ys, 0, cyc);
                check("rnd_fetch_n", fetch_q.size(), 2);
                check("rnd_fetch0", fetch_q.size() > 0 ? fetch_q[0] : 18'h3FFFF, {c, hf, ys});
            end
            ok_mode = 0;
            hs_pulse; flip = 1'($urandom);
            read_line(1); flip = 1'b0;
        end

        // reset mid-DRAW: four pixels written, then abort; draw accepted right after release
        code = 13'h0001; xpos = 9'h040; pal = 5'd3; hflip = 0; ysub = 4'd5;
        draw = 1'b1; tick; draw = 1'b0;
        model_draw(13'h0001, 9'h040, 5'd3, 1'b0, 4'd5, ~mrb, 4);
        repeat (5) tick;
        rst = 1'b1; #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_rom_cs", rom_cs, 0);
        tick; rst = 1'b0; mrb = 1'b0;
        do_draw(13'h0001, 9'h080, 5'd9, 1'b1, 4'd5, 0, cyc);
        check("post_rst_busy_cycles", cyc, 19);
        hs_pulse; read_line(1);
        hs_pulse; read_line(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/jtkiwi_objdraw.md
JTKIWI_OBJDRAW -- requirements
Module: jtkiwi_objdraw

Interface
REQ-001 rst  input  1  asynchronous reset, active-high.
REQ-002 clk  input  1  clock; all state is updated on the rising edge of clk.
REQ-003 pxl_cen  input  1  pixel clock enable for the read-out side.
REQ-004 hs  input  1  horizontal sync; a rising edge swaps the line-buffer banks.
REQ-005 flip  input  1  screen flip, read side only.
REQ-006 draw  input  1  one-cycle start pulse for one 16-pixel sprite row.
REQ-007 code  input  13  sprite tile code.
REQ-008 xpos  input  9  left screen column of the sprite.
REQ-009 pal  input  5  palette number.
REQ-010 hflip  input  1  mirror the row horizontally.
REQ-011 ysub  input  4  row within the 16-row tile, with vflip already applied by the caller.
REQ-012 busy  output  1  high from draw acceptance until the last pixel write.
REQ-013 rom_addr  output  18  SDRAM word address [19:2].
REQ-014 rom_cs  output  1  SDRAM request.
REQ-015 rom_ok  input  1  SDRAM data valid.
REQ-016 rom_data  input  32  8 pixels at 4bpp; pixel n (n=0 leftmost) is bits [4n+3:4n].
REQ-017 hdump  input  9  read-out column.
REQ-018 pxl  output  9  {pal, colour}; 0 means transparent.

Function
REQ-019 The line buffer SHALL be two banks, each 512 x 9 bits; the write bank is the complement of the read bank.
REQ-020 A rising edge of hs SHALL toggle the read bank, detected from hs registered in clk.
REQ-021 FSM states SHALL be IDLE, REQ, DRAW; transitions:
  - IDLE -> REQ on draw.
  - REQ -> DRAW on rom_cs & rom_ok.
  - DRAW -> REQ after 8 pixels of the first half.
  - DRAW -> IDLE after 8 pixels of the second half.
REQ-022 On draw in IDLE, the block SHALL latch code, xpos, pal, hflip, ysub and the current write bank.
  - busy and rom_cs go high on the next cycle.
  - draw while busy SHALL be ignored.
REQ-023 rom_addr SHALL be {code, half, ysub}.
  - half = 0 for the first fetch, 1 for the second; both are XOR hflip.
  - rom_addr SHALL be held stable while rom_cs is high.
REQ-024 rom_data SHALL be captured on the cycle rom_cs & rom_ok are both high; rom_cs SHALL drop on the next cycle.
  - rom_ok while rom_cs is low SHALL be ignored.
REQ-025 DRAW SHALL write one pixel per clk, 8 clks per half.
  - Pixel index p = 0..15 covers both halves.
  - Nibble order within each word is reversed when hflip = 1.
  - Write address = (xpos + p) mod 512; 9-bit wrap, so xpos = 0x1FC wraps to columns 0..11.
REQ-026 A pixel with colour nibble 0 SHALL NOT be written; earlier sprites keep their pixels.
  - A later non-zero pixel overwrites an earlier one.
REQ-027 Writes SHALL go to the latched bank even if hs toggles mid-sprite.
REQ-028 busy SHALL fall on the cycle after the 16th pixel slot.
  - Minimum latency is draw + 1 (REQ), + 1 per ROM wait cycle, + 8 (DRAW), twice.
  - With rom_ok already high, busy falls 19 cycles after draw.
REQ-029 Read-out on pxl_cen SHALL do both of the following:
  - Load pxl from the read bank at address (flip ? ~hdump : hdump).
  - Write 0 to that same location on the following clk (erase-after-read).
REQ-030 If a write and an erase target the same bank and address in the same cycle, the erase SHALL win.

Reset
REQ-031 During rst the block SHALL hold: state = IDLE, busy = 0, rom_cs = 0, rom_addr = 0, pxl = 0, read bank = 0.
  - Buffer RAM contents are not cleared.
REQ-032 rst asserted mid-sprite SHALL abort the sprite immediately; no further writes occur after release.
REQ-033 After rst release the block SHALL accept draw on the first clk.

Verification
REQ-034 Basic draw:
  - Stimulus: code = 0x0001, xpos = 0x010, pal = 3, hflip = 0, ysub = 5; rom_ok tied high; ROM words 0x87654321 and 0x0FEDCBA9.
  - Required: rom_addr = 0x00025 then 0x00035; busy for 19 cycles.
  - After the hs edge: hdump 0x10..0x1F read {3,1},{3,2}..{3,8},{3,9}..{3,F}.
  - hdump 0x1F reads 0, because that nibble is 0 and is not written.
REQ-035 hflip:
  - Stimulus: same as REQ-034 with hflip = 1.
  - Required: first fetch has half = 1; hdump 0x11 reads {3,F}, 0x17 reads {3,9}, 0x18 reads {3,8}.
REQ-036 Wrap-around:
  - Stimulus: xpos = 0x1FC.
  - Required: pixels appear at columns 0x1FC..0x1FF, then 0x000..0x00B.
REQ-037 SDRAM stall and ignored draw:
  - Stimulus: rom_ok low for 5 cycles; a second draw pulse while busy.
  - Required: rom_addr stable and rom_cs high throughout the stall; the second draw is ignored; busy lasts 24 cycles.
REQ-038 Erase:
  - Stimulus: read a line, then two hs edges with no draws.
  - Required: the same bank reads all 0.
REQ-039 Flip:
  - Stimulus: flip = 1, pixel written at 0x010.
  - Required: the pixel appears at hdump = 0x1EF.
  - Also: rst pulse mid-DRAW -> busy = 0 and rom_cs = 0 at once.
